// File: rtl/v810_pkg.sv
// Shared types and widths for the V810 instruction cache.
// The CHCW register image and the tag-RAM entry layout live here.
package v810_pkg;

    localparam int DATAW_DEF = 8;
    localparam int ADDRW     = 30;
    localparam int TAGW      = ADDRW - DATAW_DEF;
    localparam int IDXW      = DATAW_DEF - 1;
    localparam int ITAGW     = 28;
    localparam int CNTW      = 12;

    typedef struct packed {
        logic [CNTW-1:0] cec;
        logic [CNTW-1:0] cen;
        logic            icr;
        logic            icd;
        logic            ice;
        logic            icc;
    } chcw_t;

    typedef struct packed {
        logic [ITAGW-TAGW-3:0] pad;
        logic [1:0]            valid;
        logic [TAGW-1:0]       tag;
    } itag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_CLEAR
    } state_t;

    // Architectural read-back layout of CHCW.
    function automatic logic [31:0] chcw_pack(input chcw_t c);
        return {c.cec, c.cen, 2'b00, c.icr, c.icd, 2'b00, c.ice, c.icc};
    endfunction

endpackage

// File: rtl/v810_icache_ram.sv
// Generic single-port synchronous RAM, read-first, registered read data.
// All activity is qualified by the clock enable.
module v810_icache_ram #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          ce_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/v810_icache.sv
// V810 1 KiB direct-mapped instruction cache with per-word valid bits.
// Owns CHCW, sequences lookups, bus fills and CHCW-initiated tag clears.
module v810_icache
    import v810_pkg::*;
#(
    parameter int DATAW = DATAW_DEF
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        EUI_REQ,
    input  logic [29:0] EUI_A,
    output logic        EUI_ACK,
    output logic [31:0] EUI_D,
    output logic        BUS_REQ,
    output logic [29:0] BUS_A,
    input  logic        BUS_ACK,
    input  logic [31:0] BUS_D,
    input  logic        CHCW_WE,
    input  logic [31:0] CHCW_DI,
    output logic [31:0] CHCW_DO,
    output logic        ICMAINT
);

    localparam int IW = DATAW - 1;

    state_t      state_q, state_d;
    chcw_t       chcw_q, chcw_d;
    logic        ack_q, ack_d;
    logic [31:0] eui_d_q, eui_d_d;

    logic          tag_we;
    logic [IW-1:0] tag_addr;
    itag_t         tag_wdata;
    itag_t         tag_rdata;
    logic          data_we;
    logic [31:0]   data_rdata;

    logic                  a_word;
    logic [IW-1:0]         a_index;
    logic [ADDRW-DATAW-1:0] a_tag;
    logic [1:0]            word_mask;
    logic                  tag_match;
    logic                  hit;
    logic                  clear_req;
    logic                  unused_bits;

    assign a_word    = EUI_A[0];
    assign a_index   = EUI_A[DATAW-1:1];
    assign a_tag     = EUI_A[ADDRW-1:DATAW];
    assign word_mask = a_word ? 2'b10 : 2'b01;
    assign tag_match = (tag_rdata.tag == a_tag);
    assign hit       = tag_match && tag_rdata.valid[a_word];
    assign clear_req = CHCW_WE && CHCW_DI[0];

    assign unused_bits = ^{CHCW_DI[7:2], tag_rdata.pad};

    v810_icache_ram #(.DW(ITAGW), .AW(IW)) itagram (
        .clk_i   (CLK),
        .ce_i    (CE),
        .we_i    (tag_we),
        .addr_i  (tag_addr),
        .wdata_i (tag_wdata),
        .rdata_o (tag_rdata)
    );

    v810_icache_ram #(.DW(32), .AW(DATAW)) idataram (
        .clk_i   (CLK),
        .ce_i    (CE),
        .we_i    (data_we),
        .addr_i  (EUI_A[DATAW-1:0]),
        .wdata_i (BUS_D),
        .rdata_o (data_rdata)
    );

    always_comb begin
        state_d   = state_q;
        chcw_d    = chcw_q;
        ack_d     = 1'b0;
        eui_d_d   = eui_d_q;
        tag_we    = 1'b0;
        tag_addr  = a_index;
        tag_wdata = '0;
        data_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending or incoming clear beats the fetch; the cycle that
                // still shows EUI_ACK must not restart the held request.
                if (chcw_q.icc || clear_req) begin
                    state_d = ST_CLEAR;
                end else if (EUI_REQ && !ack_q && !CHCW_WE) begin
                    state_d = chcw_q.ice ? ST_LOOKUP : ST_FILL;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    ack_d   = 1'b1;
                    eui_d_d = data_rdata;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (BUS_ACK) begin
                    ack_d   = 1'b1;
                    eui_d_d = BUS_D;
                    state_d = ST_IDLE;
                    if (chcw_q.ice) begin
                        data_we         = 1'b1;
                        tag_we          = 1'b1;
                        tag_wdata.tag   = a_tag;
                        tag_wdata.valid = (tag_match ? tag_rdata.valid : 2'b00) | word_mask;
                    end
                end
            end
            ST_CLEAR: begin
                tag_addr = chcw_q.cen[IW-1:0];
                if (chcw_q.cec != '0) begin
                    tag_we     = 1'b1;
                    chcw_d.cen = chcw_q.cen + 1'b1;
                    chcw_d.cec = chcw_q.cec - 1'b1;
                end else begin
                    chcw_d.icc = 1'b0;
                    chcw_d.cen = '0;
                    chcw_d.cec = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (CHCW_WE) begin
            chcw_d.ice = CHCW_DI[1];
            if (CHCW_DI[0]) begin
                chcw_d.cen = CHCW_DI[19:8];
                chcw_d.cec = CHCW_DI[31:20];
                chcw_d.icc = 1'b1;
            end
        end
        chcw_d.icr = 1'b0;
        chcw_d.icd = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
            chcw_q  <= '0;
            ack_q   <= 1'b0;
            eui_d_q <= '0;
        end else if (CE) begin
            state_q <= state_d;
            chcw_q  <= chcw_d;
            ack_q   <= ack_d;
            eui_d_q <= eui_d_d;
        end
    end

    assign EUI_ACK = ack_q;
    assign EUI_D   = eui_d_q;
    assign BUS_REQ = (state_q == ST_FILL);
    assign BUS_A   = EUI_A;
    assign ICMAINT = (state_q == ST_CLEAR);
    assign CHCW_DO = chcw_pack(chcw_q);

endmodule

// File: tb/tb_v810_icache.sv
// Randomized self-checking bench for v810_icache against a behavioural
// cache model (tag/valid/data arrays updated by the architectural rules).
module tb_v810_icache;
    import v810_pkg::*;

    logic        CLK = 1'b0;
    logic        RES, CE, EUI_REQ, BUS_ACK, CHCW_WE;
    logic [29:0] EUI_A;
    logic [31:0] BUS_D, CHCW_DI;
    logic        EUI_ACK, BUS_REQ, ICMAINT;
    logic [31:0] EUI_D, CHCW_DO;
    logic [29:0] BUS_A;

    int n_checks = 0;
    int n_fails  = 0;

    logic [21:0] m_tag  [128];
    logic [1:0]  m_val  [128];
    logic [31:0] m_data [256];
    bit          m_ice;

    always #5 CLK = ~CLK;

    v810_icache dut (
        .CLK(CLK), .RES(RES), .CE(CE),
        .EUI_REQ(EUI_REQ), .EUI_A(EUI_A), .EUI_ACK(EUI_ACK), .EUI_D(EUI_D),
        .BUS_REQ(BUS_REQ), .BUS_A(BUS_A), .BUS_ACK(BUS_ACK), .BUS_D(BUS_D),
        .CHCW_WE(CHCW_WE), .CHCW_DI(CHCW_DI), .CHCW_DO(CHCW_DO), .ICMAINT(ICMAINT)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // EU protocol: nothing may be requested or acknowledged during maintenance.
    always @(negedge CLK) begin
        if (!RES && CE && ICMAINT) chk("maint_excl", {62'b0, EUI_REQ, EUI_ACK}, 64'b0);
    end

    task automatic compare_tags(input string tg);
        int bad;
        logic [27:0] e;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            e = {4'b0, m_val[i], m_tag[i]};
            if (dut.itagram.mem[i] !== e) bad++;
        end
        chk(tg, bad, 0);
    endtask

    // Called and returns at posedge+1.
    task automatic chcw_write(input logic [31:0] v);
        int cnt, k, cec, cen;
        logic [31:0] e;
        CE = 1'b1; CHCW_WE = 1'b1; CHCW_DI = v;
        @(posedge CLK); #1;
        CHCW_WE = 1'b0;
        m_ice = v[1];
        if (v[0]) begin
            cec = int'(v[31:20]);
            cen = int'(v[19:8]);
            for (int j = 0; j < cec; j++) begin
                m_tag[(cen + j) % 128] = '0;
                m_val[(cen + j) % 128] = '0;
            end
            @(negedge CLK);
            e = {v[31:8], 6'b0, v[1], 1'b1};
            chk("chcw_latch", CHCW_DO, e);
            @(posedge CLK); #1;
            cnt = 1;
            for (k = 0; k < 5000; k++) begin
                @(negedge CLK);
                if (!ICMAINT) break;
                cnt++;
                @(posedge CLK); #1;
            end
            if (k == 5000) chk("clear_timeout", 0, 1);
            @(posedge CLK); #1;
            chk("maint_cycles", cnt, cec + 1);
        end
        @(negedge CLK);
        e = {30'b0, v[1], 1'b0};
        chk("chcw_do", CHCW_DO, e);
        @(posedge CLK); #1;
    endtask

    // One EU fetch with a bus responder; optionally an ICE-only CHCW write
    // collides with the request on its first cycle.
    task automatic fetch(input logic [29:0] a, input bit ce_rand,
                         input bit with_chcw, input bit chcw_ice);
        int idx, w, delay, ce_cnt, lat, cyc;
        bit exp_hit, acked, done, bus_seen;
        logic [21:0] t;
        logic [31:0] bd, got, exp_d;
        t = a[29:8]; idx = int'(a[7:1]); w = int'(a[0]);
        bd = $urandom; delay = $urandom_range(0, 3);
        acked = 0; done = 0; bus_seen = 0; ce_cnt = 0; lat = 0; got = '0;
        if (with_chcw) begin
            CHCW_WE = 1'b1; CHCW_DI = {30'b0, chcw_ice, 1'b0}; m_ice = chcw_ice;
        end
        exp_hit = m_ice && m_val[idx][w] && (m_tag[idx] == t);
        EUI_A = a; EUI_REQ = 1'b1;
        for (cyc = 0; cyc < 400 && !done; cyc++) begin
            CE = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge CLK);
            if (EUI_ACK && !acked) begin acked = 1; got = EUI_D; lat = ce_cnt; end
            if (BUS_REQ && !bus_seen) begin bus_seen = 1; chk("bus_a", BUS_A, a); end
            if (BUS_REQ && !BUS_ACK) begin
                if (delay == 0) begin BUS_ACK = 1'b1; BUS_D = bd; end
                else delay--;
            end
            @(posedge CLK);
            if (CE) begin ce_cnt++; if (acked) done = 1; end
            #1;
            if (CE) begin BUS_ACK = 1'b0; CHCW_WE = 1'b0; end
        end
        EUI_REQ = 1'b0; CE = 1'b1; CHCW_WE = 1'b0; BUS_ACK = 1'b0;
        if (!acked) chk("fetch_timeout", 0, 1);
        exp_d = exp_hit ? m_data[a[7:0]] : bd;
        chk("eui_d", got, exp_d);
        chk("bus_used", bus_seen, !exp_hit);
        if (exp_hit) chk("hit_lat", lat, 2 + (with_chcw ? 1 : 0));
        if (!exp_hit && m_ice) begin
            m_data[a[7:0]] = bd;
            if (m_tag[idx] == t) m_val[idx] = m_val[idx] | (2'b01 << w);
            else begin m_tag[idx] = t; m_val[idx] = 2'b01 << w; end
        end
    endtask

    initial begin
        logic [27:0] e_tag;
        logic [29:0] a;
        logic [31:0] v;
        RES = 1'b1; CE = 1'b1; EUI_REQ = 1'b0; EUI_A = '0; BUS_ACK = 1'b0;
        BUS_D = '0; CHCW_WE = 1'b0; CHCW_DI = '0; m_ice = 0;
        repeat (3) @(posedge CLK);
        #1 RES = 1'b0;
        @(negedge CLK);
        chk("reset", {CHCW_DO, EUI_ACK, BUS_REQ, ICMAINT}, '0);
        @(posedge CLK); #1;

        for (int i = 0; i < 128; i++) dut.itagram.mem[i] = 28'h0A5A5A5 + 28'(i);

        // Full clear of all 128 entries.
        chcw_write({12'd128, 12'd0, 8'h03});
        compare_tags("clear_all_tags");

        fetch(30'h200000FD, 0, 0, 0);
        e_tag = {4'b0, 2'b10, 22'h200000};
        chk("tag_7E", dut.itagram.mem[7'h7E], e_tag);
        chk("data_FD", dut.idataram.mem[8'hFD], m_data[8'hFD]);

        fetch(30'h200000FE, 0, 0, 0);
        fetch(30'h200000FF, 0, 0, 0);
        e_tag = {4'b0, 2'b11, 22'h200000};
        chk("tag_7F", dut.itagram.mem[7'h7F], e_tag);
        chk("data_FE", dut.idataram.mem[8'hFE], m_data[8'hFE]);
        chk("data_FF", dut.idataram.mem[8'hFF], m_data[8'hFF]);
        fetch(30'h200000FE, 0, 0, 0);

        fetch(30'h20000004, 0, 0, 0);
        fetch(30'h20000005, 0, 0, 0);
        e_tag = {4'b0, 2'b11, 22'h200000};
        chcw_write(32'h0000_0000);
        chk("tag_02_dis", dut.itagram.mem[7'h02], e_tag);
        fetch(30'h20000004, 0, 0, 0);
        chk("tag_02_byp", dut.itagram.mem[7'h02], e_tag);
        chk("data_04_byp", dut.idataram.mem[8'h04], m_data[8'h04]);

        // Re-enable with ICD/ICR set: ignored, old entries still hit.
        chcw_write(32'h0000_0032);
        fetch(30'h20000004, 0, 0, 0);

        // Collision of CHCW write with a fetch: fetch waits one cycle.
        fetch(30'h20000005, 0, 1, 1);

        // Wrapping clear 7E,7F,00,01 and a zero-count clear.
        chcw_write({12'd4, 12'h07E, 8'h03});
        compare_tags("clear_wrap_tags");
        chcw_write({12'd0, 12'h055, 8'h03});

        for (int n = 0; n < 200; n++) begin
            a[29:8] = ($urandom_range(0, 1) != 0) ? 22'h200000 : 22'h000001;
            a[7:1]  = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 5))
                                                  : 7'($urandom_range(124, 127));
            a[0]    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                v = {12'($urandom_range(0, 6)), 12'($urandom_range(0, 127)), 6'b0, 1'b1, 1'b1};
                chcw_write(v);
            end else if ($urandom_range(0, 14) == 0) begin
                chcw_write({30'b0, ($urandom_range(0, 3) != 0), 1'b0});
            end
            if ($urandom_range(0, 19) == 0)
                fetch(a, $urandom_range(0, 1) != 0, 1, $urandom_range(0, 3) != 0);
            else
                fetch(a, $urandom_range(0, 1) != 0, 0, 0);
        end
        compare_tags("random_tags");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
